// File: rtl/bpm_pkg.sv
// Shared definitions for the heart-rate path: pulse count width, ceiling and FSM states.
package bpm_pkg;

    localparam int unsigned PULSE_W   = 8;
    localparam int unsigned PULSE_MAX = 255;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

endpackage

// File: rtl/pulse_debounce.sv
// Synchronizes the raw sensor line, debounces it and emits a one-cycle pulse
// on each accepted rising transition.
module pulse_debounce
    import bpm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pulse_in,
    output logic rise_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // The flip is taken on the D-th consecutive differing sample, so the
    // counter only needs to reach D-1.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_lvl != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_lvl;
                rise_d  = sync_lvl;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/heart_pulse_counter.sv
// Counts debounced sensor pulses over back-to-back fixed windows and publishes
// a saturating 8-bit count with a one-cycle strobe at the end of each window.
module heart_pulse_counter
    import bpm_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC   = 50_000_000,
    parameter int unsigned WINDOW_SEC      = 10,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pulse_in,
    input  logic               enable,
    output logic [PULSE_W-1:0] pulse_count,
    output logic               count_valid,
    output logic               saturated,
    output logic               window_active
);

    localparam int unsigned WINDOW  = TICKS_PER_SEC * WINDOW_SEC;
    localparam int unsigned TIMER_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned ACC_W   = PULSE_W + 1;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [PULSE_W-1:0]   count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 sat_q, sat_d;
    logic                 active_q, active_d;
    logic                 rise;
    logic [ACC_W-1:0]     acc_sum;
    logic                 terminal;

    pulse_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .pulse_in(pulse_in),
        .rise_o  (rise)
    );

    assign acc_sum  = acc_q + ACC_W'(rise);
    assign terminal = (timer_q == TIMER_W'(WINDOW - 1));

    // Enable is checked before the terminal cycle so an abort always wins.
    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        acc_d    = '0;
        count_d  = count_q;
        valid_d  = 1'b0;
        sat_d    = sat_q;
        active_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = COUNT;
                    active_d = 1'b1;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    active_d = 1'b1;
                    if (terminal) begin
                        valid_d = 1'b1;
                        sat_d   = (acc_sum > ACC_W'(PULSE_MAX));
                        count_d = sat_d ? PULSE_W'(PULSE_MAX) : acc_sum[PULSE_W-1:0];
                    end else begin
                        timer_d = timer_q + 1'b1;
                        acc_d   = (acc_sum > ACC_W'(PULSE_MAX + 1)) ? ACC_W'(PULSE_MAX + 1) : acc_sum;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
            active_q <= active_d;
        end
    end

    assign pulse_count   = count_q;
    assign count_valid   = valid_q;
    assign saturated     = sat_q;
    assign window_active = active_q;

endmodule
